// File: rtl/gb_mem_map.sv
// Memory-map constants and DMA state encoding shared by the CPU-side bus blocks.
package gb_mem_map;
  localparam logic [15:0] REG_DMA   = 16'hFF46;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;
  localparam int          DMA_BYTES = 160;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } dma_state_t;
endpackage

// File: rtl/oam_dma.sv
// OAM DMA for FF46: copies BYTES bytes from {src_hi,00} to OAM, one read + one write cycle per byte.
// HRAM accesses steal the bus for a cycle and stall the copy; other CPU accesses are blocked while busy.
module oam_dma
  import gb_mem_map::*;
#(
  parameter int          BYTES    = DMA_BYTES,
  parameter logic [15:0] OAM_BASE = gb_mem_map::OAM_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        rd_cpu_n,
  input  logic        wr_cpu_n,
  output logic [15:0] A_mem,
  output logic [7:0]  Do_mem,
  input  logic [7:0]  Di_mem,
  output logic        rd_mem_n,
  output logic        wr_mem_n,
  output logic        dma_active
);

  dma_state_t state, state_nx;
  logic [7:0] idx, idx_nx;
  logic [7:0] src_hi;
  logic [7:0] src_eff;
  logic [7:0] data_q;
  logic       reg_wr_q;

  logic hit_reg, cpu_rd, cpu_wr, reg_wr, start, in_hram, active, stall, idx_last;

  assign hit_reg  = (A_cpu == REG_DMA);
  assign cpu_rd   = ~rd_cpu_n;
  assign cpu_wr   = ~wr_cpu_n;
  assign reg_wr   = cpu_wr & hit_reg;
  // A held-low write strobe must only start one transfer, so trigger on its first cycle.
  assign start    = reg_wr & ~reg_wr_q;
  assign in_hram  = (A_cpu >= HRAM_LO) && (A_cpu <= HRAM_HI);
  assign active   = (state != IDLE);
  assign stall    = active & in_hram & (cpu_rd | cpu_wr);
  assign idx_last = (idx == 8'(BYTES - 1));
  assign src_eff  = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;

  assign dma_active = active;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 8'h00;
      src_hi   <= 8'hFF;
      data_q   <= 8'h00;
      reg_wr_q <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      reg_wr_q <= reg_wr;
      if (start) src_hi <= Di_cpu;
      if (state == READ && !stall) data_q <= Di_mem;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (start) begin
      state_nx = READ;
      idx_nx   = 8'h00;
    end else if (!stall) begin
      case (state)
        READ:    state_nx = WRITE;
        WRITE: begin
          idx_nx   = idx + 8'd1;
          state_nx = idx_last ? IDLE : READ;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Bus mux: CPU pass-through (FF46 never forwarded) unless the DMA owns this cycle.
  always_comb begin
    A_mem    = A_cpu;
    Do_mem   = Di_cpu;
    rd_mem_n = rd_cpu_n | hit_reg;
    wr_mem_n = wr_cpu_n | hit_reg;
    if (active && !stall) begin
      case (state)
        READ: begin
          A_mem    = {src_eff, idx};
          rd_mem_n = 1'b0;
          wr_mem_n = 1'b1;
        end
        WRITE: begin
          A_mem    = OAM_BASE + {8'h00, idx};
          Do_mem   = data_q;
          rd_mem_n = 1'b1;
          wr_mem_n = 1'b0;
        end
        default: begin
          rd_mem_n = 1'b1;
          wr_mem_n = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    if (hit_reg && cpu_rd)      Do_cpu = src_hi;
    else if (active && !in_hram) Do_cpu = 8'hFF;
    else                        Do_cpu = Di_mem;
  end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A_cpu = 16'h0000;
  logic [7:0]  Di_cpu = 8'h00;
  logic [7:0]  Do_cpu;
  logic        rd_cpu_n = 1'b1;
  logic        wr_cpu_n = 1'b1;
  logic [15:0] A_mem;
  logic [7:0]  Do_mem;
  logic [7:0]  Di_mem;
  logic        rd_mem_n;
  logic        wr_mem_n;
  logic        dma_active;

  int compared = 0;
  int errors   = 0;
  int act_cnt  = 0;

  // Memory: preloaded contents plus whatever the bus has written since.
  logic [7:0] src_mem [0:65535];
  logic [7:0] bus_mem [0:65535];
  bit         wrote   [0:65535];

  // Expected bus writes, {addr, data}.
  logic [23:0] exp_q [$];

  oam_dma dut (
    .clock(clock), .reset(reset), .A_cpu(A_cpu), .Di_cpu(Di_cpu), .Do_cpu(Do_cpu),
    .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr_cpu_n), .A_mem(A_mem), .Do_mem(Do_mem),
    .Di_mem(Di_mem), .rd_mem_n(rd_mem_n), .wr_mem_n(wr_mem_n), .dma_active(dma_active)
  );

  always #5 clock = ~clock;

  assign Di_mem = wrote[A_mem] ? bus_mem[A_mem] : src_mem[A_mem];

  always @(posedge clock) begin
    if (!wr_mem_n) begin
      bus_mem[A_mem] <= Do_mem;
      wrote[A_mem]   <= 1'b1;
    end
  end

  always @(negedge clock) if (dma_active) act_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every bus write must be the next one the model predicts.
  always @(negedge clock) begin
    if (wr_mem_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bus_write", {8'h00, A_mem, Do_mem}, 32'hFFFFFFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("bus_write", {8'h00, A_mem, Do_mem}, {8'h00, e});
      end
    end
  end

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return wrote[a] ? bus_mem[a] : src_mem[a];
  endfunction

  function automatic logic [7:0] eff_page(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  // Model of a transfer: OAM[i] = mem[page*256 + i] for every byte, in order.
  task automatic issue(input logic [7:0] v);
    logic [15:0] a;
    A_cpu = 16'hFF46; Di_cpu = v; wr_cpu_n = 1'b0;
    @(posedge clock); #1;
    wr_cpu_n = 1'b1; A_cpu = 16'h0000;
    exp_q.delete();
    for (int i = 0; i < 160; i++) begin
      a = {eff_page(v), 8'h00} + 16'(i);
      exp_q.push_back({16'hFE00 + 16'(i), src_mem[a]});
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (dma_active && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk(nm, {31'd0, dma_active}, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_oam(input string nm, input logic [7:0] v);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem_rd(16'hFE00 + 16'(i)) !== src_mem[{eff_page(v), 8'h00} + 16'(i)]) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int a = 0; a < 65536; a++) src_mem[a] = 8'($urandom);
    for (int i = 0; i < 160; i++) src_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // 1: reset state and idle pass-through
    A_cpu = 16'hFF46; rd_cpu_n = 1'b0;
    @(negedge clock);
    chk("reset_ff46_read", Do_cpu, 8'hFF);
    chk("reset_active", dma_active, 1'b0);
    chk("ff46_read_not_forwarded", rd_mem_n, 1'b1);
    @(posedge clock); #1 A_cpu = 16'h1234;
    @(negedge clock);
    chk("idle_rd_mirror", rd_mem_n, rd_cpu_n);
    chk("idle_read_data", Do_cpu, src_mem[16'h1234]);
    @(posedge clock); #1;
    rd_cpu_n = 1'b1; A_cpu = 16'h8000; Di_cpu = 8'h3C; wr_cpu_n = 1'b0;
    exp_q.push_back({16'h8000, 8'h3C});
    @(posedge clock); #1 wr_cpu_n = 1'b1;
    chk("idle_write_landed", mem_rd(16'h8000), 8'h3C);

    // 2: plain transfer from C100
    base = act_cnt;
    issue(8'hC1);
    @(negedge clock);
    chk("first_read_addr", A_mem, 16'hC100);
    wait_idle("t2_done");
    chk("t2_active_cycles", act_cnt - base, 320);
    check_oam("t2_oam", 8'hC1);

    // 3: blocked CPU accesses during DMA
    base = act_cnt;
    issue(8'hC1);
    repeat (20) @(posedge clock);
    #1 A_cpu = 16'h0150; rd_cpu_n = 1'b0;
    @(negedge clock);
    chk("blocked_read", Do_cpu, 8'hFF);
    @(posedge clock); #1;
    rd_cpu_n = 1'b1; A_cpu = 16'hC000; Di_cpu = 8'h77; wr_cpu_n = 1'b0;
    @(posedge clock); #1 wr_cpu_n = 1'b1; A_cpu = 16'h0000;
    wait_idle("t3_done");
    chk("t3_active_cycles", act_cnt - base, 320);
    chk("c000_untouched", {31'd0, wrote[16'hC000]}, 32'd0);

    // 4: one-cycle HRAM stall during the byte-5 read
    base = act_cnt;
    issue(8'hC1);
    repeat (10) @(posedge clock);
    #1 A_cpu = 16'hFF90; rd_cpu_n = 1'b0;
    @(negedge clock);
    chk("stall_addr", A_mem, 16'hFF90);
    chk("stall_rd", rd_mem_n, 1'b0);
    chk("hram_read_data", Do_cpu, src_mem[16'hFF90]);
    @(posedge clock); #1 rd_cpu_n = 1'b1; A_cpu = 16'h0000;
    @(negedge clock);
    chk("resume_addr", A_mem, 16'hC105);
    wait_idle("t4_done");
    chk("t4_active_cycles", act_cnt - base, 321);
    check_oam("t4_oam", 8'hC1);

    // 5: restart from D000 after byte 80
    issue(8'hC1);
    repeat (162) @(posedge clock);
    #1 issue(8'hD0);
    @(negedge clock);
    chk("restart_addr", A_mem, 16'hD000);
    @(posedge clock); #1 A_cpu = 16'hFF46; rd_cpu_n = 1'b0;
    @(negedge clock);
    chk("ff46_readback", Do_cpu, 8'hD0);
    @(posedge clock); #1 rd_cpu_n = 1'b1; A_cpu = 16'h0000;
    wait_idle("t5_done");
    check_oam("t5_oam", 8'hD0);

    // 6: echo-page source, then reset at byte 40
    issue(8'hE2);
    @(negedge clock);
    chk("echo_addr", A_mem, 16'hC200);
    repeat (80) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("reset_mid_active", dma_active, 1'b0);
    repeat (10) @(posedge clock);
    #1 chk("no_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule
